// File: rtl/req_onehot_arbiter_4.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : req_onehot_arbiter_4
// Purpose  : Synchronizes four asynchronous request lines and captures their
//            rising edges as pending events. It then grants one pending event
//            at a time as a registered one-hot word, which feeds the I input
//            of a 4-to-2 encoder. Simultaneous events are served round-robin.
//            Each grant is held until the consumer acknowledges it.
// Revision : 1.0 - initial release
// ============================================================================
module req_onehot_arbiter_4 #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] R,
  input  logic       ACK,
  output logic [3:0] I,
  output logic       BUSY,
  output logic [3:0] PEND
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // After reset the synchronizer chains and history flops hold zeros. They
  // do not hold real samples of R, so edge detection stays masked until both
  // stages are refilled. A line that is already high at reset release is
  // therefore absorbed as a level, and no event is reported for it.
  localparam int c_warm_max = SYNC_STAGES + 1;
  localparam int c_warm_w   = $clog2(c_warm_max + 1);

  logic [3:0]          w_sync_out;
  logic [3:0]          r_hist;
  logic [3:0]          w_rise;
  logic [c_warm_w-1:0] r_warm;
  logic                w_armed;

  logic [3:0] r_pend;
  logic [3:0] w_clr;
  logic [1:0] r_ptr;
  logic [1:0] w_ptr_nxt;
  logic [1:0] r_gidx;
  logic [1:0] w_gidx_nxt;
  logic [3:0] r_grant;
  logic [3:0] w_grant_nxt;
  logic       r_busy;
  logic       w_busy_nxt;
  state_t     r_state;
  state_t     w_state_nxt;

  logic       w_sel_found;
  logic [1:0] w_sel_idx;
  logic [1:0] w_cand;

  // --------------------------------------------------------------------------
  // Per-bit synchronizer chains
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < 4; gi++) begin : g_sync
    logic [SYNC_STAGES-1:0] r_chain;

    // Shift the raw request level into this bit's synchronizer chain.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_chain <= '0;
      end else begin
        r_chain <= {r_chain[SYNC_STAGES-2:0], R[gi]};
      end
    end

    assign w_sync_out[gi] = r_chain[SYNC_STAGES-1];
  end

  // Remember the previous synchronized level so that a 0->1 step can be seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hist <= '0;
    end else begin
      r_hist <= w_sync_out;
    end
  end

  // Count edges since reset until the sync and history flops carry real samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_warm <= '0;
    end else if (!w_armed) begin
      r_warm <= r_warm + c_warm_w'(1);
    end
  end

  assign w_armed = (r_warm == c_warm_w'(c_warm_max));
  assign w_rise  = w_sync_out & ~r_hist & {4{w_armed}};

  // --------------------------------------------------------------------------
  // Pending events. A set always wins over a clear on the same bit, so a new
  // rise that coincides with the acknowledge of that bit is kept.
  // --------------------------------------------------------------------------
  // Saturating pending-bit update: clear on acknowledge, set on rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= '0;
    end else begin
      r_pend <= (r_pend & ~w_clr) | w_rise;
    end
  end

  // --------------------------------------------------------------------------
  // Round-robin selection: first pending bit at PTR, PTR+1, PTR+2, PTR+3.
  // The loop runs from the farthest offset down to the nearest, so the
  // nearest pending bit is the last one written and takes priority.
  // --------------------------------------------------------------------------
  // Find the first pending bit in search order, starting at the pointer.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_idx   = r_ptr;
    w_cand      = r_ptr;
    for (int k = 3; k >= 0; k--) begin
      w_cand = r_ptr + 2'(k);
      if (r_pend[w_cand]) begin
        w_sel_found = 1'b1;
        w_sel_idx   = w_cand;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Grant FSM
  // --------------------------------------------------------------------------
  // Register the FSM state, the grant word, the busy flag and the pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_busy  <= 1'b0;
      r_ptr   <= '0;
      r_gidx  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_busy  <= w_busy_nxt;
      r_ptr   <= w_ptr_nxt;
      r_gidx  <= w_gidx_nxt;
    end
  end

  // Next-state logic. From IDLE, grant the first pending event. In GRANT,
  // hold until ACK, then release. IDLE always lasts at least one cycle, so
  // the encoder's V drops between two consecutive grants.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_busy_nxt  = r_busy;
    w_ptr_nxt   = r_ptr;
    w_gidx_nxt  = r_gidx;
    w_clr       = '0;
    case (r_state)
      ST_IDLE: begin
        w_grant_nxt = '0;
        w_busy_nxt  = 1'b0;
        if (w_sel_found) begin
          w_state_nxt = ST_GRANT;
          w_grant_nxt = 4'b0001 << w_sel_idx;
          w_busy_nxt  = 1'b1;
          w_gidx_nxt  = w_sel_idx;
        end
      end
      ST_GRANT: begin
        if (ACK) begin
          w_clr       = r_grant;
          w_ptr_nxt   = r_gidx + 2'd1;
          w_grant_nxt = '0;
          w_busy_nxt  = 1'b0;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  assign I    = r_grant;
  assign BUSY = r_busy;
  assign PEND = r_pend;

endmodule
`default_nettype wire

// File: tb/tb_req_onehot_arbiter_4.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_req_onehot_arbiter_4
// Purpose  : Scoreboard bench for req_onehot_arbiter_4. A reference model
//            reacts to the stimulus and pushes the expected grants into a
//            queue. A negedge monitor pops that queue and compares it with
//            the DUT's outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_req_onehot_arbiter_4;

  localparam int SS = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] R   = 4'b0000;
  logic       ACK = 1'b0;
  logic [3:0] I;
  logic       BUSY;
  logic [3:0] PEND;

  int total = 0;
  int bad   = 0;

  req_onehot_arbiter_4 #(.SYNC_STAGES(SS)) dut (
    .clk  (clk),
    .rst  (rst),
    .R    (R),
    .ACK  (ACK),
    .I    (I),
    .BUSY (BUSY),
    .PEND (PEND)
  );

  always #5 clk = ~clk;

  // Compare one observed value against the value the bench expects.
  function automatic void check(string name, logic [3:0] act, logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endfunction

  // --------------------------------------------------------------------------
  // Reference model. It keeps a history of R as sampled at each edge. An
  // event is seen when the sample taken SS edges ago is high and the sample
  // one edge before that is low. Samples from before reset count as high, so
  // a line held across reset is never an event.
  // --------------------------------------------------------------------------
  logic [3:0] m_hist[$];
  logic [3:0] m_pend;
  bit         m_busy;
  int         m_idx;
  int         m_ptr;
  logic [3:0] exp_q[$];

  function automatic void model_reset();
    m_hist.delete();
    for (int j = 0; j < SS + 2; j++) m_hist.push_back(4'hF);
    m_pend = 4'b0000;
    m_busy = 1'b0;
    m_idx  = 0;
    m_ptr  = 0;
    exp_q.delete();
  endfunction

  // Advance the model one clock edge, or clear it when reset is applied.
  always @(posedge clk or posedge rst) begin : model_step
    logic [3:0] rise;
    logic [3:0] clr;
    bit         found;
    if (rst) begin
      model_reset();
    end else begin
      m_hist.push_back(R);
      if (m_hist.size() > SS + 2) void'(m_hist.pop_front());
      rise = m_hist[m_hist.size() - 1 - SS] & ~m_hist[m_hist.size() - 2 - SS];
      clr  = 4'b0000;
      if (m_busy) begin
        if (ACK) begin
          clr[m_idx] = 1'b1;
          m_ptr      = (m_idx + 1) % 4;
          m_busy     = 1'b0;
        end
      end else if (m_pend != 4'b0000) begin
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
          if (!found && m_pend[(m_ptr + k) % 4]) begin
            m_idx = (m_ptr + k) % 4;
            found = 1'b1;
          end
        end
        m_busy = 1'b1;
        exp_q.push_back(4'(1 << m_idx));
      end
      m_pend = (m_pend & ~clr) | rise;
    end
  end

  // --------------------------------------------------------------------------
  // Monitor: runs on the falling edge, pops one expected grant whenever I
  // goes from zero to a new value, and checks PEND and BUSY every cycle.
  // --------------------------------------------------------------------------
  logic [3:0] prev_i = 4'b0000;
  int         n_grants = 0;
  logic [3:0] glog[$];

  always @(negedge clk) begin : monitor
    logic [3:0] e;
    if (rst) begin
      prev_i = 4'b0000;
    end else begin
      check("pend", PEND, m_pend);
      check("busy", {3'b000, BUSY}, {3'b000, m_busy});
      check("onehot", {3'b000, ((I & (I - 4'd1)) == 4'd0)}, 4'd1);
      if (!m_busy) check("idle_i", I, 4'b0000);
      if (I != 4'b0000 && prev_i == 4'b0000) begin
        n_grants++;
        glog.push_back(I);
        if (exp_q.size() == 0) begin
          check("grant_unexpected", I, 4'b0000);
        end else begin
          e = exp_q.pop_front();
          check("grant", I, e);
        end
      end
      prev_i = I;
    end
  end

  // Run n cycles. In auto mode ACK follows BUSY, which acknowledges each
  // grant at its first GRANT edge.
  task automatic run(int n, bit auto_ack);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (auto_ack) ACK = BUSY;
    end
  endtask

  task automatic check_cleared(string name);
    check({name, "_i"}, I, 4'b0000);
    check({name, "_busy"}, {3'b000, BUSY}, 4'b0000);
    check({name, "_pend"}, PEND, 4'b0000);
  endtask

  initial begin : stim
    int n0;
    int t;
    int bitsel;
    model_reset();
    rst = 1'b1;
    R   = 4'b0000;
    ACK = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    run(8, 1'b1);

    // Round-robin over four simultaneous rises.
    glog.delete();
    R = 4'b1111;
    run(20, 1'b1);
    check("rr_count", 4'(glog.size()), 4'd4);
    if (glog.size() == 4) begin
      check("rr_0", glog[0], 4'b0001);
      check("rr_1", glog[1], 4'b0010);
      check("rr_2", glog[2], 4'b0100);
      check("rr_3", glog[3], 4'b1000);
    end

    // The pointer has wrapped to 0, so bit 0 goes first.
    R = 4'b0000;
    run(6, 1'b1);
    glog.delete();
    R = 4'b1001;
    run(20, 1'b1);
    check("wrap_count", 4'(glog.size()), 4'd2);
    if (glog.size() == 2) begin
      check("wrap_0", glog[0], 4'b0001);
      check("wrap_1", glog[1], 4'b1000);
    end

    // Asynchronous reset with all lines high; held lines give no grant.
    R = 4'b0000;
    run(6, 1'b1);
    ACK = 1'b0;
    R   = 4'b1111;
    run(2, 1'b0);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check_cleared("rst_async");
    @(negedge clk);
    rst = 1'b0;
    n0  = n_grants;
    run(30, 1'b1);
    check("rst_held_grants", 4'(n_grants - n0), 4'd0);

    // A stray ACK while idle changes nothing.
    R = 4'b0000;
    run(6, 1'b1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      ACK = 1'b1;
      check("stray_busy", {3'b000, BUSY}, 4'b0000);
      check("stray_pend", PEND, 4'b0000);
    end
    @(negedge clk);
    ACK = 1'b0;

    // A level held high for 50 cycles is exactly one event.
    glog.delete();
    n0 = n_grants;
    R  = 4'b1000;
    run(50, 1'b1);
    check("held_grants", 4'(n_grants - n0), 4'd1);
    if (glog.size() > 0) check("held_word", glog[0], 4'b1000);

    // Set-wins collision on bit 1.
    R = 4'b0000;
    run(6, 1'b1);
    ACK = 1'b0;
    R   = 4'b0010;
    t   = 0;
    while (!BUSY && t < 30) begin
      @(negedge clk);
      t++;
    end
    check("col_first", I, 4'b0010);
    R = 4'b0000;
    run(5, 1'b0);
    R = 4'b0010;
    repeat (SS) @(negedge clk);
    ACK = 1'b1;
    @(negedge clk);
    ACK = 1'b0;
    check("col_gap_i", I, 4'b0000);
    check("col_pend1", {3'b000, PEND[1]}, 4'd1);
    @(negedge clk);
    check("col_regrant", I, 4'b0010);
    run(10, 1'b1);

    // Reset in the middle of a grant while PEND is 1010.
    R = 4'b0000;
    run(6, 1'b1);
    ACK = 1'b0;
    R   = 4'b1010;
    t   = 0;
    while (!(PEND == 4'b1010 && BUSY) && t < 30) begin
      @(negedge clk);
      t++;
    end
    check("mid_pend", PEND, 4'b1010);
    @(posedge clk);
    #3 rst = 1'b1;
    R = 4'b0000;
    #1 check_cleared("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    n0  = n_grants;
    run(20, 1'b0);
    check("mid_after_grants", 4'(n_grants - n0), 4'd0);
    check("mid_after_i", I, 4'b0000);

    // Random traffic checked against the model.
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        bitsel    = int'($urandom_range(0, 3));
        R[bitsel] = ~R[bitsel];
      end
      ACK = ($urandom_range(0, 2) == 0);
    end

    // Drain the remaining events and confirm nothing was left unmatched.
    R = 4'b0000;
    run(40, 1'b1);
    check("drain_queue", 4'(exp_q.size()), 4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
